// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: register map, STATUS/CTRL bit
// positions and the default byte shifted out when nothing is queued.
package spi_target_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

   localparam int ST_RX_FULL   = 0;
   localparam int ST_TX_EMPTY  = 1;
   localparam int ST_OVERRUN   = 2;
   localparam int ST_UNDERRUN  = 3;
   localparam int ST_CS_ACTIVE = 4;
   localparam int ST_BUSY      = 5;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_RXIE  = 1;
   localparam int CTRL_TXIE  = 2;
   localparam int CTRL_ERRIE = 3;

   localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus a history flop
// so single-cycle rise/fall strobes can be derived from the synced level.
module spi_target_sync #(
   parameter logic IDLE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   // Synchronizer chain and history flop, all reset to the pin's idle level.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make the three flops shift together;
      // blocking ones would collapse the chain into a single stage.
      if (rst) begin
         meta_q <= IDLE;
         sync_q <= IDLE;
         hist_q <= IDLE;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign level = sync_q;
   assign rise  = sync_q & ~hist_q;
   assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with single-byte RX/TX holding registers, a byte-wide
// CPU register port (DATA/STATUS/CTRL) and a maskable interrupt request.
module spi_target
   import spi_target_pkg::*;
#(
   parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq,
   input  logic       spi_sclk,
   input  logic       spi_mosi,
   input  logic       spi_cs_n,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   output logic [3:0] diag
);

   logic sclk_sync, sclk_rise, sclk_fall;
   logic mosi_sync, mosi_rise, mosi_fall;
   logic cs_n_sync, cs_n_rise, cs_n_fall;
   logic unused_mosi_edges;

   spi_target_sync #(.IDLE(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .async_in(spi_sclk),
      .level(sclk_sync), .rise(sclk_rise), .fall(sclk_fall));
   spi_target_sync #(.IDLE(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .async_in(spi_mosi),
      .level(mosi_sync), .rise(mosi_rise), .fall(mosi_fall));
   spi_target_sync #(.IDLE(1'b1)) u_sync_cs_n (
      .clk(clk), .rst(rst), .async_in(spi_cs_n),
      .level(cs_n_sync), .rise(cs_n_rise), .fall(cs_n_fall));

   // MOSI is only sampled as a level; its edge strobes have no consumer.
   assign unused_mosi_edges = mosi_rise | mosi_fall;

   logic       cs_q;
   logic [3:0] ctrl_q;
   logic       rx_full, tx_empty, overrun, underrun;
   logic [7:0] rx_shift, rx_data, tx_hold, tx_shift;
   logic [2:0] bit_cnt;
   logic       oe_q;

   logic       en, cs_active, reg_stb;
   logic       rd_data, wr_data, wr_status, wr_ctrl;
   logic       frame_start, sclk_rise_act, sclk_fall_act;
   logic       byte_done, tx_load, rx_store, rx_overrun;
   logic [7:0] rx_byte;

   assign en        = ctrl_q[CTRL_EN];
   assign cs_active = ~cs_n_sync;

   // Register side effects fire once per cs assertion, however long it is held.
   assign reg_stb   = cs & ~cs_q;
   assign rd_data   = reg_stb & ~we & (addr == ADDR_DATA);
   assign wr_data   = reg_stb &  we & (addr == ADDR_DATA);
   assign wr_status = reg_stb &  we & (addr == ADDR_STATUS);
   assign wr_ctrl   = reg_stb &  we & (addr == ADDR_CTRL);

   assign frame_start   = en & cs_n_fall;
   assign sclk_rise_act = en & cs_active & sclk_rise;
   assign sclk_fall_act = en & cs_active & sclk_fall & (bit_cnt != 3'd0);
   assign byte_done     = sclk_rise_act & (bit_cnt == 3'd7);
   assign tx_load       = frame_start | byte_done;
   assign rx_byte       = {rx_shift[6:0], mosi_sync};
   // A DATA read in the completion cycle frees the slot, so the byte is kept.
   assign rx_store      = byte_done & (~rx_full | rd_data);
   assign rx_overrun    = byte_done & rx_full & ~rd_data;

   // Previous-cycle cs, used to find the first cycle of a register access.
   always_ff @(posedge clk) begin
      if (rst) cs_q <= 1'b0;
      else     cs_q <= cs;
   end

   // CTRL register.
   always_ff @(posedge clk) begin
      if (rst)          ctrl_q <= 4'h0;
      else if (wr_ctrl) ctrl_q <= din[3:0];
   end

   // STATUS flags; hardware set events win over W1C clears.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_full  <= 1'b0;
         tx_empty <= 1'b1;
         overrun  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (rx_store)     rx_full <= 1'b1;
         else if (rd_data) rx_full <= 1'b0;
         if (wr_data)      tx_empty <= 1'b0;
         else if (tx_load) tx_empty <= 1'b1;
         overrun  <= (overrun  & ~(wr_status & din[ST_OVERRUN]))  | rx_overrun;
         underrun <= (underrun & ~(wr_status & din[ST_UNDERRUN])) | (tx_load & tx_empty);
      end
   end

   // Receive shifter and RX holding register.
   always_ff @(posedge clk) begin
      // NOTE: the data registers are reset as well so a DATA read straight
      // after reset returns a defined value rather than power-up garbage.
      if (rst) begin
         rx_shift <= 8'h00;
         rx_data  <= 8'h00;
      end else begin
         if (sclk_rise_act) rx_shift <= rx_byte;
         if (rx_store)      rx_data  <= rx_byte;
      end
   end

   // TX holding register and transmit shifter; a reload sees pre-write state.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_hold  <= 8'h00;
         tx_shift <= FILL_BYTE;
      end else begin
         if (wr_data) tx_hold <= din;
         if (tx_load)            tx_shift <= tx_empty ? FILL_BYTE : tx_hold;
         else if (sclk_fall_act) tx_shift <= {tx_shift[6:0], 1'b0};
      end
   end

   // Bit counter and MISO output enable, framed by CS_n and gated by EN.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= 3'd0;
         oe_q    <= 1'b0;
      end else if (~en | cs_n_rise) begin
         bit_cnt <= 3'd0;
         oe_q    <= 1'b0;
      end else if (frame_start) begin
         bit_cnt <= 3'd0;
         oe_q    <= 1'b1;
      end else if (sclk_rise_act) begin
         bit_cnt <= bit_cnt + 3'd1;
      end
   end

   // Read mux for the addressed register.
   always_comb begin
      // NOTE: default first so every path assigns dout and no latch is inferred.
      dout = 8'h00;
      case (addr)
         ADDR_DATA:   dout = rx_data;
         ADDR_STATUS: dout = {2'b00, (bit_cnt != 3'd0), cs_active,
                              underrun, overrun, tx_empty, rx_full};
         ADDR_CTRL:   dout = {4'h0, ctrl_q};
         default:     dout = 8'h00;
      endcase
   end

   assign irq = en & ((ctrl_q[CTRL_RXIE]  & rx_full)  |
                      (ctrl_q[CTRL_TXIE]  & tx_empty) |
                      (ctrl_q[CTRL_ERRIE] & (overrun | underrun)));

   assign spi_miso    = tx_shift[7];
   assign spi_miso_oe = oe_q;
   assign diag        = {cs_active, sclk_sync, mosi_sync, spi_miso};

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: register table, directed SPI
// sequences for the corner cases, and a randomized run against a
// transaction-level model of the target.
module tb_spi_target;
   import spi_target_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cs = 1'b0, we = 1'b0;
   logic [1:0] addr = 2'd0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       irq;
   logic       spi_sclk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
   logic       spi_miso, spi_miso_oe;
   logic [3:0] diag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_target dut (
      .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
      .dout(dout), .irq(irq), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .diag(diag));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; addr = a; din = d;
      tick(1);
      cs = 1'b0; we = 1'b0;
      tick(1);
   endtask

   task automatic reg_rd(input logic [1:0] a, output logic [7:0] d);
      cs = 1'b1; we = 1'b0; addr = a;
      #3;
      d = dout;
      tick(1);
      cs = 1'b0;
      tick(1);
   endtask

   task automatic rd_check(input string name, input logic [1:0] a, input logic [7:0] exp);
      logic [7:0] v;
      reg_rd(a, v);
      check(name, v, exp);
   endtask

   task automatic spi_sel();
      spi_cs_n = 1'b0;
      tick(6);
   endtask

   task automatic spi_desel();
      tick(4);
      spi_cs_n = 1'b1;
      tick(6);
   endtask

   // Controller side, mode 0 at clk/8: sends the top n bits of mo, samples MISO on each rise.
   task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         spi_mosi = mo[i];
         tick(4);
         mi[i] = spi_miso;
         spi_sclk = 1'b1;
         tick(4);
         spi_sclk = 1'b0;
      end
   endtask

   typedef struct {
      logic       we;
      logic [1:0] a;
      logic [7:0] d;
      logic [7:0] exp;
      logic       exp_irq;
   } vec_t;

   vec_t       tbl[10];
   logic [7:0] rd, mi, mo, v, w, exp_mi;
   logic [3:0] c;
   int         lat, nb;
   bit         m_full, m_ovr, m_und, m_has_tx;
   logic [7:0] m_rx, m_tx;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b0, ADDR_STATUS, 8'h00, 8'h02, 1'b0};
      tbl[1] = '{1'b0, ADDR_CTRL,   8'h00, 8'h00, 1'b0};
      tbl[2] = '{1'b0, 2'd3,        8'h00, 8'h00, 1'b0};
      tbl[3] = '{1'b0, ADDR_DATA,   8'h00, 8'h00, 1'b0};
      tbl[4] = '{1'b1, ADDR_CTRL,   8'h0F, 8'h00, 1'b1};
      tbl[5] = '{1'b0, ADDR_CTRL,   8'h00, 8'h0F, 1'b1};
      tbl[6] = '{1'b1, ADDR_DATA,   8'hA5, 8'h00, 1'b0};
      tbl[7] = '{1'b0, ADDR_STATUS, 8'h00, 8'h00, 1'b0};
      tbl[8] = '{1'b1, ADDR_CTRL,   8'hF1, 8'h00, 1'b0};
      tbl[9] = '{1'b0, ADDR_CTRL,   8'h00, 8'h01, 1'b0};

      // Reset
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      check("reset_irq", irq, 1'b0);
      check("reset_oe", spi_miso_oe, 1'b0);
      check("reset_miso", spi_miso, 1'b1);

      // Register table
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].we) reg_wr(tbl[i].a, tbl[i].d);
         else begin
            reg_rd(tbl[i].a, rd);
            check($sformatf("tbl%0d_dout", i), rd, tbl[i].exp);
         end
         check($sformatf("tbl%0d_irq", i), irq, tbl[i].exp_irq);
      end

      // Single byte: A5 queued, controller sends 3C
      spi_sel();
      check("single_oe_on", spi_miso_oe, 1'b1);
      check("single_diag_cs", diag[3], 1'b1);
      spi_bits(8'h3C, 8, mi);
      check("single_miso", mi, 8'hA5);
      spi_desel();
      check("single_oe_off", spi_miso_oe, 1'b0);
      rd_check("single_status_full", ADDR_STATUS, 8'h0B);
      rd_check("single_data", ADDR_DATA, 8'h3C);
      rd_check("single_status_read", ADDR_STATUS, 8'h0A);
      reg_wr(ADDR_STATUS, 8'h0C);
      rd_check("single_status_clr", ADDR_STATUS, 8'h02);

      // Underrun then overrun
      spi_sel();
      spi_bits(8'h11, 8, mi);
      check("ur_miso0", mi, 8'hFF);
      spi_bits(8'h22, 8, mi);
      check("ur_miso1", mi, 8'hFF);
      spi_desel();
      rd_check("ur_status", ADDR_STATUS, 8'h0F);
      rd_check("ur_data", ADDR_DATA, 8'h11);
      reg_wr(ADDR_STATUS, 8'h0C);
      rd_check("ur_status_clr", ADDR_STATUS, 8'h02);

      // Abort after 5 edges, then a full byte
      reg_wr(ADDR_DATA, 8'h5A);
      spi_sel();
      spi_bits(8'hF0, 5, mi);
      check("abort_miso_part", mi, 8'h58);
      rd_check("abort_status_busy", ADDR_STATUS, 8'h32);
      spi_desel();
      rd_check("abort_status_idle", ADDR_STATUS, 8'h02);
      reg_wr(ADDR_DATA, 8'h7E);
      spi_sel();
      spi_bits(8'h81, 8, mi);
      check("abort_miso_full", mi, 8'h7E);
      spi_desel();
      rd_check("abort_status_full", ADDR_STATUS, 8'h0B);
      rd_check("abort_data", ADDR_DATA, 8'h81);
      reg_wr(ADDR_STATUS, 8'h0C);

      // irq latency with RXIE
      reg_wr(ADDR_CTRL, 8'h03);
      check("irq_idle", irq, 1'b0);
      spi_sel();
      spi_bits(8'hC3, 7, mi);
      spi_mosi = 1'b1;
      tick(4);
      check("irq_pre_8th", irq, 1'b0);
      spi_sclk = 1'b1;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         if (irq) begin
            lat = k;
            break;
         end
      end
      check("irq_rise_latency_ok", (lat >= 1 && lat <= 4), 1'b1);
      tick(4);
      spi_sclk = 1'b0;
      spi_desel();
      cs = 1'b1; we = 1'b0; addr = ADDR_DATA;
      #3;
      check("irq_during_read", irq, 1'b1);
      check("irq_read_data", dout, 8'hC3);
      tick(1);
      check("irq_after_read", irq, 1'b0);
      cs = 1'b0;
      tick(1);
      reg_wr(ADDR_CTRL, 8'h01);
      reg_wr(ADDR_STATUS, 8'h0C);

      // Held cs: DATA read spanning the completion of a second byte
      spi_sel();
      spi_bits(8'h4D, 8, mi);
      spi_bits(8'hB2, 7, mi);
      spi_mosi = 1'b0;
      tick(4);
      spi_sclk = 1'b1;
      tick(1);
      cs = 1'b1; we = 1'b0; addr = ADDR_DATA;
      #3;
      check("held_first", dout, 8'h4D);
      tick(3);
      cs = 1'b0;
      tick(3);
      spi_sclk = 1'b0;
      spi_desel();
      reg_rd(ADDR_STATUS, rd);
      check("held_rx_full", rd[ST_RX_FULL], 1'b1);
      check("held_no_overrun", rd[ST_OVERRUN], 1'b0);
      rd_check("held_second", ADDR_DATA, 8'hB2);
      reg_wr(ADDR_STATUS, 8'h0C);

      // Randomized frames against a transaction-level model
      m_full = 1'b0; m_ovr = 1'b0; m_und = 1'b0; m_has_tx = 1'b0;
      m_rx = 8'hB2; m_tx = 8'h00;
      for (int it = 0; it < 24; it++) begin
         c = 4'($urandom_range(0, 15)) | 4'h1;
         reg_wr(ADDR_CTRL, {4'h0, c});
         if ($urandom_range(0, 1) == 1) begin
            v = 8'($urandom);
            reg_wr(ADDR_DATA, v);
            m_has_tx = 1'b1;
            m_tx = v;
         end
         nb = $urandom_range(1, 2);
         spi_sel();
         exp_mi = m_has_tx ? m_tx : FILL_BYTE_DEFAULT;
         if (!m_has_tx) m_und = 1'b1;
         m_has_tx = 1'b0;
         for (int b = 0; b < nb; b++) begin
            mo = 8'($urandom);
            spi_bits(mo, 8, mi);
            check($sformatf("rnd%0d_miso%0d", it, b), mi, exp_mi);
            if (m_full) m_ovr = 1'b1;
            else begin
               m_rx = mo;
               m_full = 1'b1;
            end
            exp_mi = FILL_BYTE_DEFAULT;
            m_und = 1'b1;
         end
         spi_desel();
         rd_check($sformatf("rnd%0d_status", it), ADDR_STATUS,
                  {4'h0, m_und, m_ovr, 1'b1, m_full});
         check($sformatf("rnd%0d_irq", it), irq,
               (c[1] & m_full) | c[2] | (c[3] & (m_ovr | m_und)));
         if ($urandom_range(0, 2) != 0) begin
            rd_check($sformatf("rnd%0d_data", it), ADDR_DATA, m_rx);
            m_full = 1'b0;
         end
         if ($urandom_range(0, 1) == 1) begin
            w = 8'($urandom) & 8'h0C;
            reg_wr(ADDR_STATUS, w);
            if (w[2]) m_ovr = 1'b0;
            if (w[3]) m_und = 1'b0;
         end
      end

      // Reset in the middle of a transfer
      reg_wr(ADDR_CTRL, 8'h01);
      reg_wr(ADDR_DATA, 8'h3D);
      spi_sel();
      spi_bits(8'hAA, 3, mi);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rst_mid_oe", spi_miso_oe, 1'b0);
      check("rst_mid_miso", spi_miso, 1'b1);
      check("rst_mid_irq", irq, 1'b0);
      rd_check("rst_mid_ctrl", ADDR_CTRL, 8'h00);
      rd_check("rst_mid_status", ADDR_STATUS, 8'h12);
      spi_desel();
      rd_check("rst_mid_status_idle", ADDR_STATUS, 8'h02);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
